// File: rtl/kitchen_key_pkg.sv
// rtl/kitchen_key_pkg.sv - shared key indices, event encodings and FSM states
//
// Purpose: common definitions for the kitchen hood key path.
//   KEY_T1..KEY_TG : bit index of each key line on key_lines
//   evt_type_t     : event type code presented on evt_type
//   key_state_t    : per-press tracking FSM states
//   max3()         : helper used to size the shared hold counter
package kitchen_key_pkg;

    localparam int unsigned KEY_ID_W = 4;

    localparam logic [KEY_ID_W-1:0] KEY_T1 = 4'd0;
    localparam logic [KEY_ID_W-1:0] KEY_T2 = 4'd1;
    localparam logic [KEY_ID_W-1:0] KEY_T3 = 4'd2;
    localparam logic [KEY_ID_W-1:0] KEY_TC = 4'd3;
    localparam logic [KEY_ID_W-1:0] KEY_TM = 4'd4;
    localparam logic [KEY_ID_W-1:0] KEY_TQ = 4'd5;
    localparam logic [KEY_ID_W-1:0] KEY_TA = 4'd6;
    localparam logic [KEY_ID_W-1:0] KEY_TW = 4'd7;
    localparam logic [KEY_ID_W-1:0] KEY_TS = 4'd8;
    localparam logic [KEY_ID_W-1:0] KEY_TE = 4'd9;
    localparam logic [KEY_ID_W-1:0] KEY_TD = 4'd10;
    localparam logic [KEY_ID_W-1:0] KEY_TT = 4'd11;
    localparam logic [KEY_ID_W-1:0] KEY_TG = 4'd12;

    typedef enum logic [1:0] {
        EVT_PRESS  = 2'b00,
        EVT_LONG   = 2'b01,
        EVT_REPEAT = 2'b10
    } evt_type_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_DEBOUNCE  = 2'b01,
        ST_HELD      = 2'b10,
        ST_LONG_HELD = 2'b11
    } key_state_t;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/key_prio_enc.sv
// rtl/key_prio_enc.sv - lowest-index-wins priority encoder for key lines
//
// Ports:
//   key_q   in  NUM_KEYS  registered key lines
//   cur_any out 1         at least one line is high
//   cur_id  out ID_W      index of the lowest high line (0 when none)
module key_prio_enc
    import kitchen_key_pkg::*;
#(
    parameter int unsigned NUM_KEYS = 13,
    parameter int unsigned ID_W     = KEY_ID_W
) (
    input  logic [NUM_KEYS-1:0] key_q,
    output logic                cur_any,
    output logic [ID_W-1:0]     cur_id
);

    // Scan from the top down so the lowest set index is the last write.
    always_comb begin
        cur_any = 1'b0;
        cur_id  = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (key_q[i]) begin
                cur_any = 1'b1;
                cur_id  = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/key_event_gen.sv
// rtl/key_event_gen.sv - debounced PRESS/LONG(/REPEAT) key event generator
//
// Turns lingering level key lines from the scan-code decoder into
// exactly-once events for the hood control FSM. One key is tracked at a
// time; the lowest-index high line wins.
// Build option: define KEY_REPEAT_EN to emit REPEAT events while a key
// stays held after LONG.
//
// Ports:
//   clk        in  1         system clock
//   rstn       in  1         asynchronous active-low reset
//   key_lines  in  NUM_KEYS  level key lines (t1,t2,t3,tc,tm,tq,ta,tw,ts,te,td,tt,tg)
//   evt_valid  out 1         event register holds an event
//   evt_ready  in  1         consumer accepts the event
//   evt_id     out 4         key index of the event
//   evt_type   out 2         00 PRESS, 01 LONG, 10 REPEAT
//   key_down   out 1         a debounced key is currently held
//   ovf        out 1         sticky: an event was dropped
//   ovf_clr    in  1         synchronous clear of ovf
module key_event_gen
    import kitchen_key_pkg::*;
#(
    parameter int unsigned NUM_KEYS      = 13,
    parameter int unsigned DEB_CYCLES    = 100000,
    parameter int unsigned LONG_CYCLES   = 100000000,
    parameter int unsigned REPEAT_CYCLES = 20000000
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [NUM_KEYS-1:0] key_lines,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [KEY_ID_W-1:0] evt_id,
    output logic [1:0]          evt_type,
    output logic                key_down,
    output logic                ovf,
    input  logic                ovf_clr
);

    localparam int unsigned CNT_MAX = max3(DEB_CYCLES, LONG_CYCLES, REPEAT_CYCLES);
    localparam int unsigned CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT   = '1;
`ifdef KEY_REPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

    logic [NUM_KEYS-1:0] key_q;
    logic                cur_any;
    logic [KEY_ID_W-1:0] cur_id;

    key_state_t          state, state_d;
    logic [CNT_W-1:0]    cnt, cnt_d, cnt_inc;
    logic [KEY_ID_W-1:0] cap_id, cap_id_d;
    logic                same_key;
    logic                post;
    evt_type_t           post_type;
    logic                drop;

    // Single register stage; the decoder output is already synchronous.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            key_q <= '0;
        end else begin
            key_q <= key_lines;
        end
    end

    key_prio_enc #(
        .NUM_KEYS (NUM_KEYS),
        .ID_W     (KEY_ID_W)
    ) u_prio_enc (
        .key_q   (key_q),
        .cur_any (cur_any),
        .cur_id  (cur_id)
    );

    // Any release or change of winning key aborts the current press.
    assign same_key = cur_any && (cur_id == cap_id);
    assign cnt_inc  = (cnt == CNT_SAT) ? cnt : cnt + 1'b1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            cap_id <= '0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            cap_id <= cap_id_d;
        end
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        cap_id_d  = cap_id;
        post      = 1'b0;
        post_type = EVT_PRESS;
        case (state)
            ST_IDLE: begin
                if (cur_any) begin
                    cap_id_d = cur_id;
                    cnt_d    = '0;
                    state_d  = ST_DEBOUNCE;
                end
            end
            ST_DEBOUNCE: begin
                if (!same_key) begin
                    state_d = ST_IDLE;
                end else if (cnt == DEB_LAST) begin
                    post      = 1'b1;
                    post_type = EVT_PRESS;
                    cnt_d     = '0;
                    state_d   = ST_HELD;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_HELD: begin
                if (!same_key) begin
                    state_d = ST_IDLE;
                end else if (cnt == LONG_LAST) begin
                    post      = 1'b1;
                    post_type = EVT_LONG;
                    cnt_d     = '0;
                    state_d   = ST_LONG_HELD;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_LONG_HELD: begin
                if (!same_key) begin
                    state_d = ST_IDLE;
                end
`ifdef KEY_REPEAT_EN
                else if (cnt == REPEAT_LAST) begin
                    post      = 1'b1;
                    post_type = EVT_REPEAT;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A post only replaces the held event when the slot is free or being
    // accepted this very cycle; otherwise it is lost and flagged.
    assign drop = post && evt_valid && !evt_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            evt_valid <= 1'b0;
            evt_id    <= '0;
            evt_type  <= 2'b00;
        end else if (post) begin
            if (!evt_valid || evt_ready) begin
                evt_valid <= 1'b1;
                evt_id    <= cap_id;
                evt_type  <= post_type;
            end
        end else if (evt_valid && evt_ready) begin
            evt_valid <= 1'b0;
        end
    end

    // Drop has priority over a simultaneous clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

    assign key_down = (state == ST_HELD) || (state == ST_LONG_HELD);

endmodule

// File: tb/tb_key_event_gen.sv
// tb/tb_key_event_gen.sv - directed self-checking bench for key_event_gen
module tb_key_event_gen;

    logic        clk = 1'b0;
    logic        rstn;
    logic [12:0] key_lines;
    logic        evt_valid;
    logic        evt_ready;
    logic [3:0]  evt_id;
    logic [1:0]  evt_type;
    logic        key_down;
    logic        ovf;
    logic        ovf_clr;

    int checks   = 0;
    int failures = 0;
    int n_evt;
    logic [8:0] bounce;

    always #5 clk = ~clk;

    key_event_gen #(
        .NUM_KEYS      (13),
        .DEB_CYCLES    (4),
        .LONG_CYCLES   (20),
        .REPEAT_CYCLES (5)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .key_lines (key_lines),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_id    (evt_id),
        .evt_type  (evt_type),
        .key_down  (key_down),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic count_events(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (evt_valid && evt_ready) cnt++;
        end
    endtask

    initial begin
        rstn      = 1'b0;
        key_lines = '0;
        evt_ready = 1'b1;
        ovf_clr   = 1'b0;
        step(2);
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_id", 32'(evt_id), 32'd0);
        chk("rst_type", 32'(evt_type), 32'd0);
        chk("rst_key_down", 32'(key_down), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        rstn = 1'b1;
        step(2);

        // Clean press of ta (index 6), 10 cycles, consumer always ready.
        key_lines[6] = 1'b1;
        step(5);
        chk("clean_early", 32'(evt_valid), 32'd0);
        step(1);
        chk("clean_valid", 32'(evt_valid), 32'd1);
        chk("clean_id", 32'(evt_id), 32'd6);
        chk("clean_type", 32'(evt_type), 32'd0);
        chk("clean_key_down", 32'(key_down), 32'd1);
        count_events(4, n_evt);
        chk("clean_single", 32'(n_evt), 32'd0);
        key_lines = '0;
        step(1);
        chk("clean_down_hold", 32'(key_down), 32'd1);
        step(1);
        chk("clean_down_drop", 32'(key_down), 32'd0);
        count_events(30, n_evt);
        chk("clean_no_long", 32'(n_evt), 32'd0);

        // Bounce on t1: high 2 / low 1, three times, then steady high.
        bounce = 9'b011011011;
        n_evt  = 0;
        for (int i = 0; i < 9; i++) begin
            key_lines[0] = bounce[i];
            @(negedge clk);
            if (evt_valid) n_evt++;
        end
        chk("bounce_quiet", 32'(n_evt), 32'd0);
        key_lines[0] = 1'b1;
        step(5);
        chk("bounce_early", 32'(evt_valid), 32'd0);
        step(1);
        chk("bounce_valid", 32'(evt_valid), 32'd1);
        chk("bounce_id", 32'(evt_id), 32'd0);
        chk("bounce_type", 32'(evt_type), 32'd0);
        key_lines = '0;
        step(3);

        // Long press on tm (index 4), held 60 cycles.
        key_lines[4] = 1'b1;
        step(6);
        chk("long_press_valid", 32'(evt_valid), 32'd1);
        chk("long_press_id", 32'(evt_id), 32'd4);
        chk("long_press_type", 32'(evt_type), 32'd0);
        step(19);
        chk("long_early", 32'(evt_valid), 32'd0);
        step(1);
        chk("long_valid", 32'(evt_valid), 32'd1);
        chk("long_id", 32'(evt_id), 32'd4);
        chk("long_type", 32'(evt_type), 32'd1);
`ifdef KEY_REPEAT_EN
        step(5);
        chk("rep1_valid", 32'(evt_valid), 32'd1);
        chk("rep1_id", 32'(evt_id), 32'd4);
        chk("rep1_type", 32'(evt_type), 32'd2);
        step(5);
        chk("rep2_valid", 32'(evt_valid), 32'd1);
        chk("rep2_type", 32'(evt_type), 32'd2);
        count_events(24, n_evt);
        chk("rep_count", 32'(n_evt), 32'd4);
`else
        count_events(34, n_evt);
        chk("long_quiet", 32'(n_evt), 32'd0);
`endif
        key_lines = '0;
        step(3);
        chk("long_released", 32'(key_down), 32'd0);

        // Backpressure: second PRESS is dropped while the first is held.
        chk("bp_ovf_start", 32'(ovf), 32'd0);
        evt_ready    = 1'b0;
        key_lines[1] = 1'b1;
        step(8);
        chk("bp_first_valid", 32'(evt_valid), 32'd1);
        chk("bp_first_id", 32'(evt_id), 32'd1);
        key_lines = '0;
        step(3);
        key_lines[2] = 1'b1;
        step(6);
        chk("bp_hold_valid", 32'(evt_valid), 32'd1);
        chk("bp_hold_id", 32'(evt_id), 32'd1);
        chk("bp_hold_type", 32'(evt_type), 32'd0);
        chk("bp_ovf_set", 32'(ovf), 32'd1);
        evt_ready = 1'b1;
        key_lines = '0;
        step(1);
        chk("bp_accepted", 32'(evt_valid), 32'd0);
        chk("bp_ovf_sticky", 32'(ovf), 32'd1);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        chk("bp_ovf_clr", 32'(ovf), 32'd0);
        step(3);

        // Accept and post on the same edge: new event replaces, no drop.
        evt_ready    = 1'b0;
        key_lines[1] = 1'b1;
        step(8);
        key_lines = '0;
        step(3);
        key_lines[2] = 1'b1;
        step(5);
        chk("same_pending_id", 32'(evt_id), 32'd1);
        evt_ready = 1'b1;
        step(1);
        chk("same_valid", 32'(evt_valid), 32'd1);
        chk("same_id", 32'(evt_id), 32'd2);
        chk("same_ovf", 32'(ovf), 32'd0);
        key_lines = '0;
        step(1);
        chk("same_drained", 32'(evt_valid), 32'd0);
        step(3);

        // Multi-key: lowest index wins; reset mid-HELD clears everything.
        evt_ready    = 1'b0;
        key_lines[3] = 1'b1;
        key_lines[9] = 1'b1;
        step(6);
        chk("multi_valid", 32'(evt_valid), 32'd1);
        chk("multi_id", 32'(evt_id), 32'd3);
        step(4);
        chk("multi_held", 32'(key_down), 32'd1);
        rstn = 1'b0;
        #1;
        chk("arst_valid", 32'(evt_valid), 32'd0);
        chk("arst_id", 32'(evt_id), 32'd0);
        chk("arst_type", 32'(evt_type), 32'd0);
        chk("arst_key_down", 32'(key_down), 32'd0);
        chk("arst_ovf", 32'(ovf), 32'd0);
        key_lines = '0;
        step(2);
        rstn      = 1'b1;
        evt_ready = 1'b1;
        count_events(30, n_evt);
        chk("arst_no_long", 32'(n_evt), 32'd0);
        chk("arst_idle", 32'(key_down), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
